// File: rtl/my_mc_ctrl_if.sv
// my_mc_ctrl_if: run/instruction/memory handshake and datapath control bundle of the
// multi-cycle controller; slave side is the controller, master side drives its inputs.
interface my_mc_ctrl_if;
  logic        run;
  logic [31:0] inst_field;
  logic        mem_ready;
  logic [3:0]  ALU_Control;
  logic [2:0]  ImmSel;
  logic [1:0]  MemtoReg;
  logic        ALUSrc_B;
  logic        Jump;
  logic        Branch;
  logic        InverseBranch;
  logic        PCOffset;
  logic        RegWrite;
  logic        PCWrite;
  logic        IRWrite;
  logic        MemReq;
  logic        MemRW;
  logic [2:0]  state;
  logic        illegal;

  modport master (
    output run, inst_field, mem_ready,
    input  ALU_Control, ImmSel, MemtoReg, ALUSrc_B, Jump, Branch, InverseBranch,
           PCOffset, RegWrite, PCWrite, IRWrite, MemReq, MemRW, state, illegal
  );

  modport slave (
    input  run, inst_field, mem_ready,
    output ALU_Control, ImmSel, MemtoReg, ALUSrc_B, Jump, Branch, InverseBranch,
           PCOffset, RegWrite, PCWrite, IRWrite, MemReq, MemRW, state, illegal
  );
endinterface

// File: rtl/my_mc_ctrl.sv
// my_mc_ctrl: multi-cycle RV32I-subset control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Define MY_MC_CTRL_MEM_TIMEOUT_EN to trap after 255 MEM cycles without mem_ready.
module my_mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  my_mc_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [2:0] IMM_I  = 3'd0;
  localparam logic [2:0] IMM_S  = 3'd1;
  localparam logic [2:0] IMM_SB = 3'd2;
  localparam logic [2:0] IMM_UJ = 3'd3;
  localparam logic [2:0] IMM_U  = 3'd4;

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  state_t      state_q, state_d;
  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic        funct7b5_s;
  logic        legal_s;
  logic [3:0]  alu_s;
  logic [2:0]  imm_s;
  logic [1:0]  m2r_s;
  logic        alusrc_s, jump_s, branch_s, invb_s, pcoff_s;
  logic        regw_s, pcw_s, irw_s, memreq_s, memrw_s;

`ifdef MY_MC_CTRL_MEM_TIMEOUT_EN
  logic [7:0]  tmo_q, tmo_d;
`endif

  assign opcode_s   = bus.inst_field[6:0];
  assign funct3_s   = bus.inst_field[14:12];
  assign funct7b5_s = bus.inst_field[30];

  // legality of the instruction held in the instruction register
  always_comb begin
    legal_s = 1'b0;
    case (opcode_s)
      OP_R, OP_I, OP_LD, OP_ST, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal_s = 1'b1;
      OP_BR:   legal_s = (funct3_s == 3'b000) || (funct3_s == 3'b001);
      default: legal_s = 1'b0;
    endcase
  end

  // datapath controls from the opcode, next state and enables from the state
  always_comb begin
    state_d  = state_q;
    alu_s    = ALU_ADD;
    imm_s    = IMM_I;
    m2r_s    = 2'd0;
    alusrc_s = 1'b0;
    jump_s   = 1'b0;
    branch_s = 1'b0;
    invb_s   = 1'b0;
    pcoff_s  = 1'b0;
    regw_s   = 1'b0;
    pcw_s    = 1'b0;
    irw_s    = 1'b0;
    memreq_s = 1'b0;
    memrw_s  = 1'b0;
`ifdef MY_MC_CTRL_MEM_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif

    case (opcode_s)
      OP_R:     alu_s = alu_op(funct3_s, funct7b5_s);
      OP_I: begin
        alu_s    = alu_op(funct3_s, funct7b5_s && (funct3_s == 3'b101));
        alusrc_s = 1'b1;
        imm_s    = IMM_I;
      end
      OP_LD: begin
        alusrc_s = 1'b1;
        imm_s    = IMM_I;
      end
      OP_ST: begin
        alusrc_s = 1'b1;
        imm_s    = IMM_S;
      end
      OP_BR: begin
        branch_s = 1'b1;
        alu_s    = ALU_SUB;
        imm_s    = IMM_SB;
        invb_s   = funct3_s[0];
      end
      OP_JAL: begin
        jump_s = 1'b1;
        imm_s  = IMM_UJ;
        m2r_s  = 2'd2;
      end
      OP_JALR: begin
        jump_s   = 1'b1;
        pcoff_s  = 1'b1;
        alusrc_s = 1'b1;
        imm_s    = IMM_I;
        m2r_s    = 2'd2;
      end
      OP_LUI: begin
        m2r_s = 2'd3;
        imm_s = IMM_U;
      end
      OP_AUIPC: begin
        m2r_s = 2'd2;
        imm_s = IMM_U;
      end
      default: alu_s = ALU_ADD;
    endcase

    case (state_q)
      S_FETCH: begin
        if (bus.run) begin
          irw_s   = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (legal_s) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_EXEC: begin
        if ((opcode_s == OP_LD) || (opcode_s == OP_ST)) begin
          state_d = S_MEM;
`ifdef MY_MC_CTRL_MEM_TIMEOUT_EN
          tmo_d   = 8'd0;
`endif
        end else begin
          pcw_s   = 1'b1;
          regw_s  = (opcode_s != OP_BR);
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        memreq_s = 1'b1;
        memrw_s  = (opcode_s == OP_ST);
        if (bus.mem_ready) begin
          if (opcode_s == OP_ST) begin
            pcw_s   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
`ifdef MY_MC_CTRL_MEM_TIMEOUT_EN
          tmo_d = tmo_q + 8'd1;
          if (tmo_q == 8'd254) begin
            state_d = S_TRAP;
          end else begin
            state_d = S_MEM;
          end
`else
          state_d = S_MEM;
`endif
        end
      end
      S_WB: begin
        regw_s  = 1'b1;
        pcw_s   = 1'b1;
        m2r_s   = 2'd1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // state register; reset forces FETCH immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MY_MC_CTRL_MEM_TIMEOUT_EN
  // MEM wait counter, cleared on MEM entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= 8'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign bus.ALU_Control   = alu_s;
  assign bus.ImmSel        = imm_s;
  assign bus.MemtoReg      = m2r_s;
  assign bus.ALUSrc_B      = alusrc_s;
  assign bus.Jump          = jump_s;
  assign bus.Branch        = branch_s;
  assign bus.InverseBranch = invb_s;
  assign bus.PCOffset      = pcoff_s;
  // enables drop with rst directly, not only through the state register
  assign bus.RegWrite      = regw_s & ~rst;
  assign bus.PCWrite       = pcw_s & ~rst;
  assign bus.IRWrite       = irw_s & ~rst;
  assign bus.MemReq        = memreq_s & ~rst;
  assign bus.MemRW         = memrw_s;
  assign bus.state         = state_q;
  assign bus.illegal       = (state_q == S_TRAP);
endmodule

// File: tb/tb_my_mc_ctrl.sv
// tb_my_mc_ctrl: directed checks plus randomized instruction stream compared each
// cycle against a per-instruction cycle-schedule model of the controller.
`timescale 1ns/1ps
module tb_my_mc_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  my_mc_ctrl_if bus ();
  my_mc_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_EXEC = 2, ST_MEM = 3, ST_WB = 4, ST_TRAP = 5;
  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_JALR = 6,
                 K_LUI = 7, K_AUIPC = 8, K_ILL = 9;
  localparam logic [6:0] LEGAL_OPS [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
      7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  int checks = 0;
  int errors = 0;
  int exp_state = ST_FETCH;
  logic [31:0] cur_inst = 32'h0;
  logic chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int kind_of(input logic [31:0] i);
    for (int n = 0; n < 9; n++)
      if (i[6:0] == LEGAL_OPS[n]) begin
        if (n == K_BR && i[14:12] > 3'd1) return K_ILL;
        return n;
      end
    return K_ILL;
  endfunction

  function automatic int alu_of(input logic [31:0] i, input int k);
    int base [8];
    int f3;
    base = '{0, 2, 3, 4, 5, 6, 8, 9};
    f3 = int'(i[14:12]);
    if (k == K_R && f3 == 0 && i[30]) return 1;
    if (f3 == 5 && i[30]) return 7;
    return base[f3];
  endfunction

  task automatic check_now();
    int k, s, irw, pcw, regw, mreq;
    k = kind_of(cur_inst);
    s = rst ? ST_FETCH : exp_state;
    irw = 0; pcw = 0; regw = 0; mreq = 0;
    if (!rst) begin
      case (s)
        ST_FETCH: irw = int'(bus.run);
        ST_EXEC: begin
          pcw  = (k != K_LD && k != K_ST);
          regw = (k != K_LD && k != K_ST && k != K_BR);
        end
        ST_MEM: begin
          mreq = 1;
          pcw  = (k == K_ST) && bus.mem_ready;
        end
        ST_WB: begin regw = 1; pcw = 1; end
        default: ;
      endcase
    end
    chk("state", bus.state, s);
    chk("illegal", bus.illegal, s == ST_TRAP);
    chk("IRWrite", bus.IRWrite, irw);
    chk("PCWrite", bus.PCWrite, pcw);
    chk("RegWrite", bus.RegWrite, regw);
    chk("MemReq", bus.MemReq, mreq);
    if (rst) return;
    if (s == ST_EXEC) begin
      chk("Branch", bus.Branch, k == K_BR);
      chk("Jump", bus.Jump, k == K_JAL || k == K_JALR);
      case (k)
        K_R: begin
          chk("ALU", bus.ALU_Control, alu_of(cur_inst, k));
          chk("MemtoReg", bus.MemtoReg, 0); chk("ALUSrc_B", bus.ALUSrc_B, 0);
        end
        K_I: begin
          chk("ALU", bus.ALU_Control, alu_of(cur_inst, k));
          chk("MemtoReg", bus.MemtoReg, 0); chk("ALUSrc_B", bus.ALUSrc_B, 1);
          chk("ImmSel", bus.ImmSel, 0);
        end
        K_LUI: begin chk("MemtoReg", bus.MemtoReg, 3); chk("ImmSel", bus.ImmSel, 4); end
        K_AUIPC: begin
          chk("MemtoReg", bus.MemtoReg, 2); chk("ImmSel", bus.ImmSel, 4);
          chk("PCOffset", bus.PCOffset, 0);
        end
        K_JAL: begin
          chk("MemtoReg", bus.MemtoReg, 2); chk("ImmSel", bus.ImmSel, 3);
          chk("PCOffset", bus.PCOffset, 0);
        end
        K_JALR: begin
          chk("MemtoReg", bus.MemtoReg, 2); chk("ImmSel", bus.ImmSel, 0);
          chk("PCOffset", bus.PCOffset, 1); chk("ALUSrc_B", bus.ALUSrc_B, 1);
          chk("ALU", bus.ALU_Control, 0);
        end
        K_BR: begin
          chk("ALU", bus.ALU_Control, 1); chk("ImmSel", bus.ImmSel, 2);
          chk("InverseBranch", bus.InverseBranch, cur_inst[12]);
        end
        default: ;
      endcase
    end
    if (s == ST_EXEC || s == ST_MEM) begin
      if (k == K_LD || k == K_ST) begin
        chk("ALU", bus.ALU_Control, 0); chk("ALUSrc_B", bus.ALUSrc_B, 1);
        chk("ImmSel", bus.ImmSel, (k == K_ST) ? 1 : 0);
      end
    end
    if (s == ST_MEM) chk("MemRW", bus.MemRW, k == K_ST);
    if (s == ST_WB) chk("MemtoReg", bus.MemtoReg, 1);
  endtask

  // one compare process: every falling edge, all outputs against the model
  always @(negedge clk) begin
    if (chk_on) check_now();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int st, input logic r, input logic [31:0] inst, input logic mr);
    exp_state = st; cur_inst = inst;
    bus.run = r; bus.inst_field = inst; bus.mem_ready = mr;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    drive(ST_FETCH, 1'b1, $urandom, 1'($urandom));
    #1;
    chk("rst_state", bus.state, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_MemReq", bus.MemReq, 0);
    chk("rst_IRWrite", bus.IRWrite, 0);
    step();
    rst = 1'b0;
  endtask

  // schedule of one instruction: stalls in FETCH, then the cycles its class takes
  task automatic run_inst(input logic [31:0] inst, input int stalls, input int waits);
    int k;
    k = kind_of(inst);
    for (int i = 0; i < stalls; i++) begin
      drive(ST_FETCH, 1'b0, $urandom, 1'($urandom)); step();
    end
    drive(ST_FETCH, 1'b1, $urandom, 1'($urandom)); step();
    drive(ST_DECODE, 1'($urandom), inst, 1'($urandom)); step();
    if (k == K_ILL) begin
      for (int i = 0; i < 3; i++) begin drive(ST_TRAP, 1'b1, inst, 1'($urandom)); step(); end
      do_reset();
      return;
    end
    drive(ST_EXEC, 1'($urandom), inst, 1'($urandom)); step();
    if (k == K_LD || k == K_ST) begin
      for (int i = 0; i <= waits; i++) begin
        drive(ST_MEM, 1'($urandom), inst, i == waits); step();
      end
      if (k == K_LD) begin drive(ST_WB, 1'($urandom), inst, 1'($urandom)); step(); end
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int sel;
    w = $urandom;
    sel = $urandom_range(0, 39);
    if (sel < 36) begin
      w[6:0] = LEGAL_OPS[sel % 9];
      if (sel % 9 == K_BR) w[14:13] = 2'b00;
    end else if (sel < 38) begin
      w[6:0] = 7'b1100011;
      w[14:12] = 3'($urandom_range(2, 7));
    end
    return w;
  endfunction

  initial begin
    logic [31:0] addi, lw, bne, sw, bad;
    int memcnt;
    addi = 32'h0050_0093;
    lw   = {12'd4, 5'd0, 3'b010, 5'd1, 7'b0000011};
    bne  = {7'd0, 5'd2, 5'd1, 3'b001, 5'd8, 7'b1100011};
    sw   = {7'd0, 5'd2, 5'd1, 3'b010, 5'd4, 7'b0100011};
    bad  = 32'h0000_007F;

    drive(ST_FETCH, 1'b1, 32'h0, 1'b0);
    chk_on = 1'b1;
    #2;
    chk("reset_state", bus.state, 0);
    chk("reset_IRWrite", bus.IRWrite, 0);
    step(); step();
    rst = 1'b0;

    // addi x1,x0,5: states 0,1,2,0
    drive(ST_FETCH, 1'b1, 32'h0, 1'b0); #1 chk("addi_irw", bus.IRWrite, 1); step();
    drive(ST_DECODE, 1'b1, addi, 1'b0); #1 chk("addi_s1", bus.state, 1);
    chk("addi_regw_dec", bus.RegWrite, 0); step();
    drive(ST_EXEC, 1'b1, addi, 1'b0); #1 chk("addi_s2", bus.state, 2);
    chk("addi_alu", bus.ALU_Control, 0); chk("addi_srcb", bus.ALUSrc_B, 1);
    chk("addi_regw", bus.RegWrite, 1); chk("addi_pcw", bus.PCWrite, 1); step();
    drive(ST_FETCH, 1'b0, 32'h0, 1'b0); #1 chk("addi_s0", bus.state, 0);
    chk("addi_pcw_off", bus.PCWrite, 0); step();

    // lw with three not-ready MEM cycles
    drive(ST_FETCH, 1'b1, 32'h0, 1'b1); step();
    drive(ST_DECODE, 1'b1, lw, 1'b1); step();
    drive(ST_EXEC, 1'b0, lw, 1'b1); step();
    memcnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive(ST_MEM, 1'b0, lw, i == 3); #1;
      if (bus.MemReq === 1'b1 && bus.MemRW === 1'b0 && bus.state === 3'd3) memcnt++;
      step();
    end
    chk("lw_mem_cycles", memcnt, 4);
    drive(ST_WB, 1'b0, lw, 1'b0); #1 chk("lw_wb_regw", bus.RegWrite, 1);
    chk("lw_wb_m2r", bus.MemtoReg, 1); step();
    drive(ST_FETCH, 1'b0, 32'h0, 1'b0); #1 chk("lw_back_fetch", bus.state, 0); step();

    // bne
    drive(ST_FETCH, 1'b1, 32'h0, 1'b0); step();
    drive(ST_DECODE, 1'b1, bne, 1'b0); step();
    drive(ST_EXEC, 1'b1, bne, 1'b0); #1;
    chk("bne_branch", bus.Branch, 1); chk("bne_inv", bus.InverseBranch, 1);
    chk("bne_alu", bus.ALU_Control, 1); chk("bne_pcw", bus.PCWrite, 1);
    chk("bne_regw", bus.RegWrite, 0); step();

    // illegal opcode traps and stays
    drive(ST_FETCH, 1'b1, 32'h0, 1'b0); step();
    drive(ST_DECODE, 1'b1, bad, 1'b0); step();
    for (int i = 0; i < 20; i++) begin drive(ST_TRAP, 1'b1, bad, 1'b1); step(); end
    chk("trap_state", bus.state, 5); chk("trap_illegal", bus.illegal, 1);
    do_reset();

    // reset between edges during a store MEM cycle
    drive(ST_FETCH, 1'b1, 32'h0, 1'b0); step();
    drive(ST_DECODE, 1'b1, sw, 1'b0); step();
    drive(ST_EXEC, 1'b1, sw, 1'b0); step();
    drive(ST_MEM, 1'b1, sw, 1'b0); #1 chk("sw_memreq", bus.MemReq, 1);
    chk("sw_memrw", bus.MemRW, 1);
    do_reset();

`ifdef MY_MC_CTRL_MEM_TIMEOUT_EN
    drive(ST_FETCH, 1'b1, 32'h0, 1'b0); step();
    drive(ST_DECODE, 1'b1, lw, 1'b0); step();
    drive(ST_EXEC, 1'b1, lw, 1'b0); step();
    for (int i = 0; i < 255; i++) begin drive(ST_MEM, 1'b1, lw, 1'b0); step(); end
    drive(ST_TRAP, 1'b1, lw, 1'b0); #1 chk("timeout_trap", bus.state, 5); step();
    do_reset();
`endif

    for (int n = 0; n < 300; n++)
      run_inst(rand_inst(), $urandom_range(0, 2), $urandom_range(0, 4));
    drive(ST_FETCH, 1'b0, 32'h0, 1'b0); step();
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
